// File: rtl/agc_frame_sel_controller.sv
// agc_frame_sel_controller
//   Per-frame sequencer for the AGC VH/VL gain-table select. Counts bright
//   pixels over a frame, classifies the count against ten fractional
//   thresholds (one compare per cycle), then applies hysteresis and a
//   one-step rate limit before updating the LUT select.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_start         single-cycle pulse on the first cycle of a frame
//   frame_end           single-cycle pulse on the last cycle of a frame
//   pix_valid, pix_data pixel qualifier and luminance sample
//   bright_th           brightness threshold (pix_data >= bright_th is bright)
//   sel                 LUT select, 0..10
//   sel_valid           one-cycle pulse after each classified frame
//   busy                high while classifying / updating
//   overflow            sticky pixel-counter saturation flag for the frame
//   frame_drop          one-cycle pulse when a frame_start is discarded
module agc_frame_sel_controller #(
  parameter int unsigned BIT_WIDTH   = 21,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned TOTAL_PIX   = 2073600,
  parameter int unsigned HYST_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [PIX_W-1:0] bright_th,
  output logic [3:0]       sel,
  output logic             sel_valid,
  output logic             busy,
  output logic             overflow,
  output logic             frame_drop
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCUM    = 2'd1;
  localparam logic [1:0] ST_CLASSIFY = 2'd2;
  localparam logic [1:0] ST_UPDATE   = 2'd3;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'd9;
  localparam logic [3:0] SEL_MAX  = 4'd10;
  localparam logic [3:0] HYST_N   = 4'(HYST_FRAMES);
  localparam logic [BIT_WIDTH-1:0] CNT_MAX = {BIT_WIDTH{1'b1}};

  // Thresholds floor(TOTAL_PIX*P/100), computed wide to avoid overflow
  localparam logic [63:0] TOT = 64'(TOTAL_PIX);
  localparam logic [63:0] TH0 = TOT * 64'd25 / 64'd100;
  localparam logic [63:0] TH1 = TOT * 64'd27 / 64'd100;
  localparam logic [63:0] TH2 = TOT * 64'd31 / 64'd100;
  localparam logic [63:0] TH3 = TOT * 64'd39 / 64'd100;
  localparam logic [63:0] TH4 = TOT * 64'd47 / 64'd100;
  localparam logic [63:0] TH5 = TOT * 64'd53 / 64'd100;
  localparam logic [63:0] TH6 = TOT * 64'd58 / 64'd100;
  localparam logic [63:0] TH7 = TOT * 64'd69 / 64'd100;
  localparam logic [63:0] TH8 = TOT * 64'd78 / 64'd100;
  localparam logic [63:0] TH9 = TOT * 64'd94 / 64'd100;

  logic [1:0]           state_q, state_d;
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           raw_q, raw_d;
  logic [3:0]           hcnt_q, hcnt_d;
  logic [1:0]           dir_q, dir_d;
  logic [3:0]           sel_q, sel_d;
  logic                 sel_valid_q, sel_valid_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;

  logic                 bright_c;
  logic [63:0]          th_c;
  logic [BIT_WIDTH-1:0] cnt_inc_c;
  logic                 ovf_inc_c;
  logic [3:0]           hcnt_nxt_c;

  assign bright_c = pix_valid && (pix_data >= bright_th);

  // Threshold for the current compare index
  always_comb begin
    th_c = TH9;
    case (idx_q)
      4'd0:    th_c = TH0;
      4'd1:    th_c = TH1;
      4'd2:    th_c = TH2;
      4'd3:    th_c = TH3;
      4'd4:    th_c = TH4;
      4'd5:    th_c = TH5;
      4'd6:    th_c = TH6;
      4'd7:    th_c = TH7;
      4'd8:    th_c = TH8;
      default: th_c = TH9;
    endcase
  end

  // Saturating count step; a blocked increment flags overflow
  always_comb begin
    cnt_inc_c = cnt_q;
    ovf_inc_c = ovf_q;
    if (bright_c) begin
      if (cnt_q == CNT_MAX) ovf_inc_c = 1'b1;
      else                  cnt_inc_c = cnt_q + BIT_WIDTH'(1);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    idx_d       = idx_q;
    raw_d       = raw_q;
    hcnt_d      = hcnt_q;
    dir_d       = dir_q;
    sel_d       = sel_q;
    sel_valid_d = 1'b0;
    drop_d      = 1'b0;
    hcnt_nxt_c  = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_ACCUM;
          cnt_d   = BIT_WIDTH'(bright_c);
          ovf_d   = 1'b0;
        end
      end

      ST_ACCUM: begin
        if (frame_end) begin
          // frame_end wins over a coincident frame_start
          cnt_d   = cnt_inc_c;
          ovf_d   = ovf_inc_c;
          state_d = ST_CLASSIFY;
          idx_d   = 4'd0;
          raw_d   = 4'd0;
          drop_d  = frame_start;
        end else if (frame_start) begin
          // abandon the partial frame and restart counting
          cnt_d = BIT_WIDTH'(bright_c);
          ovf_d = 1'b0;
        end else begin
          cnt_d = cnt_inc_c;
          ovf_d = ovf_inc_c;
        end
      end

      ST_CLASSIFY: begin
        drop_d = frame_start;
        if (64'(cnt_q) > th_c) raw_d = raw_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_UPDATE;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_UPDATE: begin
        drop_d      = frame_start;
        sel_valid_d = 1'b1;
        state_d     = ST_IDLE;
        if (raw_q == sel_q) begin
          hcnt_d = 4'd0;
          dir_d  = DIR_NONE;
        end else if (raw_q > sel_q) begin
          hcnt_nxt_c = (dir_q == DIR_UP) ? hcnt_q + 4'd1 : 4'd1;
          dir_d      = DIR_UP;
          if (hcnt_nxt_c == HYST_N) begin
            hcnt_d = 4'd0;
            if (sel_q < SEL_MAX) sel_d = sel_q + 4'd1;
          end else begin
            hcnt_d = hcnt_nxt_c;
          end
        end else begin
          hcnt_nxt_c = (dir_q == DIR_DOWN) ? hcnt_q + 4'd1 : 4'd1;
          dir_d      = DIR_DOWN;
          if (hcnt_nxt_c == HYST_N) begin
            hcnt_d = 4'd0;
            if (sel_q != 4'd0) sel_d = sel_q - 4'd1;
          end else begin
            hcnt_d = hcnt_nxt_c;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CLASSIFY) || (state_d == ST_UPDATE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      idx_q       <= 4'd0;
      raw_q       <= 4'd0;
      hcnt_q      <= 4'd0;
      dir_q       <= DIR_NONE;
      sel_q       <= 4'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
      raw_q       <= raw_d;
      hcnt_q      <= hcnt_d;
      dir_q       <= dir_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign frame_drop = drop_q;

endmodule

// File: tb/tb_agc_frame_sel_controller.sv
// Directed testbench for agc_frame_sel_controller. Three instances share the
// stimulus: A (HYST=2), B (HYST=1) and C (4-bit counter, HYST=2), all with a
// 100-pixel frame so thresholds are 25,27,31,39,47,53,58,69,78,94.
module tb_agc_frame_sel_controller;

  localparam int unsigned PIX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start, frame_end, pix_valid;
  logic [PIX_W-1:0] pix_data, bright_th;

  logic [3:0] sel_a, sel_b, sel_c;
  logic       sel_valid_a, sel_valid_b, sel_valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       overflow_a, overflow_b, overflow_c;
  logic       frame_drop_a, frame_drop_b, frame_drop_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  agc_frame_sel_controller #(.BIT_WIDTH(21), .PIX_W(PIX_W), .TOTAL_PIX(100), .HYST_FRAMES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .bright_th(bright_th),
    .sel(sel_a), .sel_valid(sel_valid_a), .busy(busy_a), .overflow(overflow_a),
    .frame_drop(frame_drop_a));

  agc_frame_sel_controller #(.BIT_WIDTH(21), .PIX_W(PIX_W), .TOTAL_PIX(100), .HYST_FRAMES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .bright_th(bright_th),
    .sel(sel_b), .sel_valid(sel_valid_b), .busy(busy_b), .overflow(overflow_b),
    .frame_drop(frame_drop_b));

  agc_frame_sel_controller #(.BIT_WIDTH(4), .PIX_W(PIX_W), .TOTAL_PIX(100), .HYST_FRAMES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .bright_th(bright_th),
    .sel(sel_c), .sel_valid(sel_valid_c), .busy(busy_c), .overflow(overflow_c),
    .frame_drop(frame_drop_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // len-cycle frame, the first nb pixels bright; optionally frame_start on the last cycle
  task automatic send_frame(input int nb, input int len, input bit start_at_end);
    for (int i = 0; i < len; i++) begin
      frame_start = (i == 0) || (start_at_end && (i == len - 1));
      frame_end   = (i == len - 1);
      pix_valid   = 1'b1;
      pix_data    = (i < nb) ? 8'd200 : 8'd10;
      @(posedge clk);
      #1;
    end
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = '0;
  endtask

  // Called in cycle T+1; waits for sel_valid, optionally injecting frame_start at T+inj
  task automatic wait_result(input string tag, input int inj);
    int lat;
    lat = -1;
    check_eq({tag, " busy"}, 32'(busy_a), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      if (k == inj) frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (k == inj) check_eq({tag, " drop"}, 32'(frame_drop_a), 32'd1);
      if (sel_valid_a) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, " latency"}, 32'(lat), 32'd11);
    check_eq({tag, " busy_off"}, 32'(busy_a), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int nb, input int inj);
    send_frame(nb, 100, 1'b0);
    wait_result(tag, inj);
  endtask

  int bnd_cnt[15] = '{25, 26, 25, 26, 95, 95, 95, 95, 95, 95, 95, 95, 94, 95, 95};
  int bnd_sel[15] = '{0, 1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 10, 10};
  bit activity;

  initial begin
    bright_th = 8'd128;
    do_reset();
    check_eq("rst sel", 32'(sel_a), 32'd0);
    check_eq("rst sel_valid", 32'(sel_valid_a), 32'd0);
    check_eq("rst busy", 32'(busy_a), 32'd0);
    check_eq("rst overflow", 32'(overflow_a), 32'd0);
    check_eq("rst frame_drop", 32'(frame_drop_a), 32'd0);

    // Hysteresis climb: 30 bright -> raw 2
    run_frame("f1", 30, 0);
    check_eq("f1 sel_a", 32'(sel_a), 32'd0);
    check_eq("f1 sel_b", 32'(sel_b), 32'd1);
    check_eq("f1 ovf_c", 32'(overflow_c), 32'd1);
    check_eq("f1 ovf_a", 32'(overflow_a), 32'd0);
    run_frame("f2", 30, 0);
    check_eq("f2 sel_a", 32'(sel_a), 32'd1);
    check_eq("f2 sel_b", 32'(sel_b), 32'd2);
    run_frame("f3", 30, 0);
    check_eq("f3 sel_b", 32'(sel_b), 32'd2);
    run_frame("f4", 30, 0);
    check_eq("f4 sel_a", 32'(sel_a), 32'd2);
    check_eq("f4 sel_b", 32'(sel_b), 32'd2);
    check_eq("f4 sel_c", 32'(sel_c), 32'd0);

    // Direction reversal: raw 5 then raw 0 twice
    run_frame("rv1", 50, 0);
    check_eq("rv1 sel_a", 32'(sel_a), 32'd2);
    run_frame("rv2", 0, 0);
    check_eq("rv2 sel_a", 32'(sel_a), 32'd2);
    run_frame("rv3", 0, 0);
    check_eq("rv3 sel_a", 32'(sel_a), 32'd1);

    // frame_start during CLASSIFY is dropped, result unaffected
    run_frame("cls_drop", 0, 3);
    check_eq("cls_drop sel_a", 32'(sel_a), 32'd1);

    // frame_start and frame_end together: classification proceeds, drop pulses
    send_frame(0, 100, 1'b1);
    check_eq("both drop", 32'(frame_drop_a), 32'd1);
    wait_result("both", 0);
    check_eq("both sel_a", 32'(sel_a), 32'd0);

    // frame_end in IDLE does nothing
    frame_end = 1'b1;
    @(posedge clk);
    #1 frame_end = 1'b0;
    activity = 1'b0;
    repeat (15) begin
      if (busy_a || sel_valid_a || busy_b || sel_valid_b) activity = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("idle_end activity", 32'(activity), 32'd0);

    // Threshold boundaries with HYST=1
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_frame("bnd", bnd_cnt[i], 0);
      check_eq($sformatf("bnd%0d sel_b", i), 32'(sel_b), 32'(bnd_sel[i]));
    end

    // Saturation of the 4-bit counter
    do_reset();
    send_frame(20, 20, 1'b0);
    wait_result("sat", 0);
    check_eq("sat ovf_c", 32'(overflow_c), 32'd1);
    check_eq("sat sel_c", 32'(sel_c), 32'd0);
    check_eq("sat ovf_a", 32'(overflow_a), 32'd0);
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 8'd10;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    check_eq("sat ovf_clr", 32'(overflow_c), 32'd0);

    // Mid-operation reset at frame_end+5
    do_reset();
    run_frame("pre", 30, 0);
    check_eq("pre sel_b", 32'(sel_b), 32'd1);
    send_frame(30, 100, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_eq("mid busy_before", 32'(busy_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid sel_b", 32'(sel_b), 32'd0);
    check_eq("mid busy", 32'(busy_a), 32'd0);
    check_eq("mid ovf_c", 32'(overflow_c), 32'd0);
    check_eq("mid sel_valid", 32'(sel_valid_a), 32'd0);
    check_eq("mid drop", 32'(frame_drop_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    activity = 1'b0;
    repeat (20) begin
      if (sel_valid_a || sel_valid_b || sel_valid_c) activity = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("mid no_sel_valid", 32'(activity), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/agc_frame_sel_controller.md
Name: agc_frame_sel_controller

Overview:
- Per-frame sequencer for the AGC VH/VL gain-table select.
- Counts bright pixels over one frame and classifies the count against ten fractional thresholds, one compare per cycle.
- Applies hysteresis and rate limiting before it updates the 4-bit select that drives the VH/VL lookup tables.
- Sits between the pixel stream front end and the VH/VL LUT mux.

Parameters:
- BIT_WIDTH, 21, width of the pixel counter.
- PIX_W, 8, pixel data width.
- TOTAL_PIX, 2073600, pixels per frame (1920*1080). Threshold k = floor(TOTAL_PIX*P[k]/100), with P = {25,27,31,39,47,53,58,69,78,94}.
- HYST_FRAMES, 2, number of consecutive same-direction frames required before sel moves by one step. Range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse marking the first cycle of a frame
- frame_end  in  1  single-cycle pulse marking the last cycle of a frame
- pix_valid  in  1  pix_data qualifier
- pix_data  in  PIX_W  luminance sample
- bright_th  in  PIX_W  brightness threshold, sampled on each valid pixel
- sel  out  4  LUT select, 0..10 (4'ha max)
- sel_valid  out  1  one-cycle pulse after each classified frame
- busy  out  1  high in CLASSIFY and UPDATE
- overflow  out  1  sticky pixel-counter saturation flag for the current frame
- frame_drop  out  1  one-cycle pulse when a frame_start is discarded

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE, pixel count = 0, compare index = 0, raw = 0.
  - Hysteresis counter = 0, direction = none.
  - sel = 0, sel_valid = 0, busy = 0, overflow = 0, frame_drop = 0.
- States: IDLE, ACCUM, CLASSIFY, UPDATE.
- IDLE:
  - frame_start moves to ACCUM and clears count and overflow.
  - frame_end is ignored. Pixels are ignored.
- ACCUM:
  - Each cycle with pix_valid=1 and pix_data >= bright_th (unsigned) increments count, including the frame_start cycle and the frame_end cycle.
  - count saturates at 2^BIT_WIDTH-1. overflow sets when an increment is blocked, and holds until the next accepted frame_start.
  - frame_start in ACCUM without frame_end: the partial frame is abandoned, count restarts (this cycle's pixel counts as 1 if bright), no sel_valid is produced.
  - frame_end moves to CLASSIFY. If frame_start arrives in the same cycle, frame_end wins and frame_drop pulses.
- CLASSIFY:
  - Exactly 10 cycles, index k = 0..9.
  - Each cycle, raw increments if count > threshold[k].
  - Result raw = number of thresholds exceeded (0..10).
- UPDATE (1 cycle): hysteresis evaluation.
  - raw == sel: hysteresis counter = 0, direction = none.
  - raw > sel: if direction is up, counter+1; otherwise counter = 1 and direction = up. If the resulting counter == HYST_FRAMES, sel = sel+1 and counter = 0.
  - raw < sel: symmetric, with direction down and sel-1.
  - sel moves by at most 1 per frame and never leaves 0..10.
- Timing:
  - frame_end in cycle T: CLASSIFY runs T+1..T+10, UPDATE is T+11.
  - The new sel and sel_valid=1 are visible in cycle T+12, then the block returns to IDLE.
  - busy = 1 in cycles T+1..T+11.
- sel_valid pulses once per classified frame, even when sel does not change.
- A frame_start while busy is discarded: frame_drop pulses for one cycle and the state is unaffected.
- Mid-operation reset: immediate return to reset values. No sel_valid for the interrupted frame.
- sel is registered and stable between updates.

Test Plan (TOTAL_PIX=100, thresholds 25,27,31,39,47,53,58,69,78,94; HYST_FRAMES=2 unless noted):
- Reset, then a 100-pixel frame with 30 bright pixels: sel_valid at frame_end+12 with sel=0 (raw=2, counter=1). Second identical frame: sel=1. Third: sel=2. Fourth: sel=2, sel_valid still pulses.
- Boundaries: count = 25 gives raw=0, count = 26 gives raw=1, count = 94 gives raw=9, count = 95 gives raw=10. Check with HYST_FRAMES=1 and sel starting from 0 and stepping.
- Direction reversal: from sel=2, frame raw=5 then frame raw=0: sel stays 2 and the counter resets to 1 with direction down. Another raw=0 frame gives sel=1.
- Control edges:
  - frame_start in CLASSIFY: frame_drop pulse, sel result unchanged.
  - frame_start and frame_end in the same cycle: classification proceeds and frame_drop pulses.
  - frame_end in IDLE: no activity.
- Saturation with BIT_WIDTH=4 and 20 bright pixels: count holds at 15, overflow=1, raw=0. overflow clears on the next frame_start.
- Assert rst_n=0 at frame_end+5: all outputs return to 0 immediately, and no sel_valid pulse occurs.
